pool_window_gen: RTL and testbench
==================================

# pool_window_gen

Streaming 3x3 window generator feeding the multicycle max-pooling stage. It accepts a raster-order stream of signed 8-bit pixels and keeps two line buffers plus a 3x3 shift window. At each stride-aligned position it emits one 9-pixel window on the same `valid`/`data0..8` interface the pooling stage consumes. The pooling stage has no ready output, so this block enforces a minimum spacing between windows and applies backpressure upstream instead.

## Interface

Parameters:
- `IMG_W`, default 8: pixels per row, ≥ 3.
- `IMG_H`, default 8: rows per frame, ≥ 3.
- `STRIDE`, default 3: window step in both directions, ≥ 1.
- `POOL_GAP`, default 4: minimum cycles between consecutive `valid_out` pulses, ≥ 1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `pix_valid` in 1: upstream pixel valid.
- `pix_in` in 8 signed: pixel, raster order (row-major, col 0 first).
- `pix_ready` out 1: block can accept a pixel this cycle (combinational).
- `valid_out` out 1: one-cycle pulse, window on `data_out0..8` is valid.
- `data_out0`..`data_out8` out 8 signed each: window, row-major; `data_out0` = (r-2,c-2), `data_out8` = (r,c).
- `frame_done` out 1: one-cycle pulse after the last pixel of a frame is accepted.
- `win_count` out 16: present only with `POOL_WIN_CNT_EN`.

## Operation

- Accept occurs when `pix_valid && pix_ready`. Position counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) describe the pixel being accepted.
- Per accept:
  - The window shifts left by one column.
  - The new right column is {`lb1[col]`, `lb0[col]`, `pix_in`}.
  - Then `lb1[col]` ← `lb0[col]` and `lb0[col]` ← `pix_in`.
  - `col` increments. On wrap, `col` clears and `row` increments. At (IMG_H-1, IMG_W-1) both clear.
- Window position: the accepted pixel is a window pixel iff `col≥2`, `row≥2`, `(col-2)%STRIDE==0` and `(row-2)%STRIDE==0`.
- Accepting a window pixel latches the post-shift window into `data_out0..8`. The outputs hold until the next window.
- Line-buffer contents are never cleared. Windows are only emitted at `row≥2` and `col≥2`, so stale data is never exposed, including across row and frame wraps.
- Spacing counter `gap_cnt`:
  - Loads `POOL_GAP-1` on accepting a window pixel; otherwise it decrements while nonzero.
  - `pix_ready` = `!(next pixel is a window pixel && gap_cnt != 0)`. Non-window pixels are never stalled.
- Arithmetic: pixels pass through unmodified. There is no sign extension or saturation.

## Timing

- Reset values:
  - Outputs: `valid_out`=0, `frame_done`=0, `data_out0..8`=0, `win_count`=0.
  - Internal: `col`=`row`=0, `gap_cnt`=0.
- Latency: window pixel accepted in cycle A gives `valid_out`=1 with data in cycle A+1, for exactly one cycle.
- Spacing: a `valid_out` at T is followed by the next one no earlier than T+POOL_GAP. With POOL_GAP=4 this matches the pooling stage's accept plus 3 compute cycles.
- `frame_done` is asserted in the cycle after the frame's last pixel is accepted. It coincides with `valid_out` when that pixel is also a window pixel.
- `pix_ready` may be high while `pix_valid` is low. A stall holds all state except `gap_cnt`, which keeps decrementing.
- If `rst` is asserted mid-frame, the next cycle behaves as frame start: position (0,0), `gap_cnt`=0, no pending pulse.

## Configuration

- `POOL_WIN_CNT_EN` defined:
  - Adds output `win_count[15:0]`, which increments in the cycle `valid_out` is asserted and wraps at 65535→0.
  - Cleared only by `rst`, not by frame wrap.
- `POOL_WIN_CNT_EN` undefined: the port and counter do not exist; all other behaviour is identical.

## Test plan

- Setup: IMG_W=IMG_H=6, STRIDE=3, POOL_GAP=4, continuous `pix_valid`, pixel value = row*6+col.
- Expected window 1: `valid_out` one cycle after pixel 14 is accepted, with `data_out0..8` = 0,1,2,6,7,8,12,13,14.
- Expected windows 2–4 in order: (2,5) = 3,4,5,9,10,11,15,16,17; (5,2) = 18,19,20,24,25,26,30,31,32; (5,5) = 21,22,23,27,28,29,33,34,35.
- Stall check: `pix_ready` is low for exactly one cycle before pixels 17 and 35. Consecutive `valid_out` pulses in the same row are 4 cycles apart.
- Frame wrap: `frame_done` pulses together with the final `valid_out` after pixel 35. A second identical frame streamed back-to-back yields the identical 4 windows.
- Reset mid-frame: assert `rst` after pixel 20, then stream a full frame. Exactly 4 windows result, matching the first scenario.
- Random `pix_valid` gaps (~50%): window contents are unchanged and `valid_out` spacing is ≥ 4. With `POOL_WIN_CNT_EN` defined, `win_count` reads 8 after two frames.

Source files
------------

// File: rtl/pool_window_gen.sv
// Streaming 3x3 window generator with two line buffers, stride-aligned window
// emission and minimum output spacing enforced through upstream backpressure.
// Optional window counter output enabled by defining POOL_WIN_CNT_EN.
module pool_window_gen #(
   parameter int IMG_W    = 8,
   parameter int IMG_H    = 8,
   parameter int STRIDE   = 3,
   parameter int POOL_GAP = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pix_valid,
   input  logic signed [7:0] pix_in,
   output logic              pix_ready,
   output logic              valid_out,
   output logic signed [7:0] data_out0,
   output logic signed [7:0] data_out1,
   output logic signed [7:0] data_out2,
   output logic signed [7:0] data_out3,
   output logic signed [7:0] data_out4,
   output logic signed [7:0] data_out5,
   output logic signed [7:0] data_out6,
   output logic signed [7:0] data_out7,
   output logic signed [7:0] data_out8,
   output logic              frame_done
`ifdef POOL_WIN_CNT_EN
   ,
   output logic [15:0]       win_count
`endif
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int GW = (POOL_GAP > 1) ? $clog2(POOL_GAP) : 1;

   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [GW-1:0] GAP_LOAD = GW'(POOL_GAP - 1);

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [GW-1:0] gap_cnt_q, gap_cnt_d;

   logic valid_out_q, valid_out_d;
   logic frame_done_q, frame_done_d;

   logic signed [7:0] lb0_q [IMG_W];
   logic signed [7:0] lb0_d [IMG_W];
   logic signed [7:0] lb1_q [IMG_W];
   logic signed [7:0] lb1_d [IMG_W];

   // Window is row-major: index 0 = (r-2,c-2), index 8 = (r,c).
   logic signed [7:0] win_q [9];
   logic signed [7:0] win_d [9];
   logic signed [7:0] data_out_q [9];
   logic signed [7:0] data_out_d [9];

   logic accept;
   logic pos_is_win;
   logic win_hit;
   logic last_pix;

   function automatic logic is_win_pos(input logic [CW-1:0] c, input logic [RW-1:0] r);
      int ci;
      int ri;
      ci = int'(c);
      ri = int'(r);
      return (ci >= 2) && (ri >= 2) &&
             (((ci - 2) % STRIDE) == 0) && (((ri - 2) % STRIDE) == 0);
   endfunction

   always_comb begin
      pos_is_win = is_win_pos(col_q, row_q);
      pix_ready  = !(pos_is_win && (gap_cnt_q != '0));
      accept     = pix_valid && pix_ready;
      win_hit    = accept && pos_is_win;
      last_pix   = (col_q == COL_LAST) && (row_q == ROW_LAST);
   end

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (accept) begin
         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   // Spacing counter keeps running through stalls so backpressure releases on time.
   always_comb begin
      gap_cnt_d = gap_cnt_q;
      if (win_hit) begin
         gap_cnt_d = GAP_LOAD;
      end else if (gap_cnt_q != '0) begin
         gap_cnt_d = gap_cnt_q - 1'b1;
      end
   end

   always_comb begin
      lb0_d = lb0_q;
      lb1_d = lb1_q;
      win_d = win_q;
      if (accept) begin
         for (int r = 0; r < 3; r++) begin
            win_d[r*3 + 0] = win_q[r*3 + 1];
            win_d[r*3 + 1] = win_q[r*3 + 2];
         end
         win_d[2]     = lb1_q[col_q];
         win_d[5]     = lb0_q[col_q];
         win_d[8]     = pix_in;
         lb1_d[col_q] = lb0_q[col_q];
         lb0_d[col_q] = pix_in;
      end
   end

   always_comb begin
      data_out_d   = data_out_q;
      valid_out_d  = win_hit;
      frame_done_d = accept && last_pix;
      if (win_hit) begin
         data_out_d = win_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q        <= '0;
         row_q        <= '0;
         gap_cnt_q    <= '0;
         valid_out_q  <= 1'b0;
         frame_done_q <= 1'b0;
         for (int i = 0; i < 9; i++) begin
            data_out_q[i] <= '0;
         end
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         gap_cnt_q    <= gap_cnt_d;
         valid_out_q  <= valid_out_d;
         frame_done_q <= frame_done_d;
         data_out_q   <= data_out_d;
      end
   end

   // Line buffers and shift window are never cleared; windows only form once
   // two full rows and columns of the current frame have been seen.
   always_ff @(posedge clk) begin
      lb0_q <= lb0_d;
      lb1_q <= lb1_d;
      win_q <= win_d;
   end

`ifdef POOL_WIN_CNT_EN
   logic [15:0] win_count_q, win_count_d;

   always_comb begin
      win_count_d = win_count_q;
      if (win_hit) begin
         win_count_d = win_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         win_count_q <= '0;
      end else begin
         win_count_q <= win_count_d;
      end
   end

   assign win_count = win_count_q;
`endif

   assign valid_out  = valid_out_q;
   assign frame_done = frame_done_q;
   assign data_out0  = data_out_q[0];
   assign data_out1  = data_out_q[1];
   assign data_out2  = data_out_q[2];
   assign data_out3  = data_out_q[3];
   assign data_out4  = data_out_q[4];
   assign data_out5  = data_out_q[5];
   assign data_out6  = data_out_q[6];
   assign data_out7  = data_out_q[7];
   assign data_out8  = data_out_q[8];

endmodule

// File: tb/tb_pool_window_gen.sv
// Scoreboard bench for pool_window_gen on a 6x6 frame, stride 3, gap 4.
module tb_pool_window_gen;
   localparam int W = 6;
   localparam int H = 6;
   localparam int S = 3;
   localparam int G = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              pix_valid = 1'b0;
   logic signed [7:0] pix_in = '0;
   logic              pix_ready;
   logic              valid_out;
   logic              frame_done;
   logic signed [7:0] data_out0, data_out1, data_out2, data_out3, data_out4;
   logic signed [7:0] data_out5, data_out6, data_out7, data_out8;
`ifdef POOL_WIN_CNT_EN
   logic [15:0]       win_count;
`endif

   pool_window_gen #(.IMG_W(W), .IMG_H(H), .STRIDE(S), .POOL_GAP(G)) dut (
      .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_in(pix_in),
      .pix_ready(pix_ready), .valid_out(valid_out),
      .data_out0(data_out0), .data_out1(data_out1), .data_out2(data_out2),
      .data_out3(data_out3), .data_out4(data_out4), .data_out5(data_out5),
      .data_out6(data_out6), .data_out7(data_out7), .data_out8(data_out8),
      .frame_done(frame_done)
`ifdef POOL_WIN_CNT_EN
      , .win_count(win_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int w;
      bit last;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   last_v = -1;
   int   win_model = 0;

   // Hand-computed windows for pixel value = row*6+col.
   int exp_tab[4][9] = '{
      '{ 0,  1,  2,  6,  7,  8, 12, 13, 14},
      '{ 3,  4,  5,  9, 10, 11, 15, 16, 17},
      '{18, 19, 20, 24, 25, 26, 30, 31, 32},
      '{21, 22, 23, 27, 28, 29, 33, 34, 35}
   };
   int win_pix[4] = '{14, 17, 32, 35};

   logic signed [7:0] dout [9];
   assign dout[0] = data_out0;
   assign dout[1] = data_out1;
   assign dout[2] = data_out2;
   assign dout[3] = data_out3;
   assign dout[4] = data_out4;
   assign dout[5] = data_out5;
   assign dout[6] = data_out6;
   assign dout[7] = data_out7;
   assign dout[8] = data_out8;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      exp_t e;
      bit   bad;
      if (!rst) begin
         if (valid_out) begin
            win_model++;
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL unexpected_window cyc=%0d got valid_out=1 want none pending", cyc);
            end else begin
               e = sb.pop_front();
               bad = 1'b0;
               for (int k = 0; k < 9; k++) begin
                  if (int'(dout[k]) != exp_tab[e.w][k]) bad = 1'b1;
               end
               if (bad) begin
                  failures++;
                  $display("FAIL window%0d cyc=%0d got %0d %0d %0d %0d %0d %0d %0d %0d %0d want %0d..%0d",
                           e.w, cyc, dout[0], dout[1], dout[2], dout[3], dout[4],
                           dout[5], dout[6], dout[7], dout[8], exp_tab[e.w][0], exp_tab[e.w][8]);
               end
               checks++;
               if (frame_done !== e.last) begin
                  failures++;
                  $display("FAIL frame_done_with_window%0d cyc=%0d got %0b want %0b",
                           e.w, cyc, frame_done, e.last);
               end
            end
            if (last_v >= 0) begin
               checks++;
               if (cyc - last_v < G) begin
                  failures++;
                  $display("FAIL spacing cyc=%0d got %0d want >=%0d", cyc, cyc - last_v, G);
               end
            end
            last_v = cyc;
`ifdef POOL_WIN_CNT_EN
            checks++;
            if (win_count !== 16'(win_model)) begin
               failures++;
               $display("FAIL win_count cyc=%0d got %0d want %0d", cyc, win_count, win_model);
            end
`endif
         end else if (frame_done) begin
            checks++;
            failures++;
            $display("FAIL stray_frame_done cyc=%0d got 1 want 0", cyc);
         end
      end
   end

   task automatic send_pixel(input int v, input bit idle, input int exp_stall);
      int st;
      st = 0;
      @(negedge clk);
      if (idle) begin
         pix_valid = 1'b0;
         @(negedge clk);
      end
      pix_valid = 1'b1;
      pix_in    = 8'(v);
      while (!pix_ready && st < 20) begin
         st++;
         @(negedge clk);
      end
      if (st >= 20) begin
         checks++;
         failures++;
         $display("FAIL ready_timeout pix=%0d got stalled %0d cycles want <20", v, st);
      end else if (exp_stall >= 0) begin
         checks++;
         if (st != exp_stall) begin
            failures++;
            $display("FAIL stall_pix%0d got %0d want %0d", v, st, exp_stall);
         end
      end
   endtask

   task automatic stream(input int n, input bit rnd, input bit chk);
      exp_t e;
      int   es;
      bit   idle;
      for (int w = 0; w < 4; w++) begin
         if (win_pix[w] < n) begin
            e.w    = w;
            e.last = (w == 3);
            sb.push_back(e);
         end
      end
      for (int p = 0; p < n; p++) begin
         idle = rnd ? ($urandom_range(0, 1) == 1) : 1'b0;
         es   = chk ? (((p == 17) || (p == 35)) ? 1 : 0) : -1;
         send_pixel(p, idle, es);
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      @(negedge clk);
      pix_valid = 1'b0;
      while (sb.size() != 0 && t < 20) begin
         t++;
         @(negedge clk);
      end
      @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain got %0d pending windows want 0", sb.size());
      end
   endtask

   initial begin
      bit bad;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (valid_out !== 1'b0 || frame_done !== 1'b0) begin
         failures++;
         $display("FAIL reset_pulses got valid_out=%0b frame_done=%0b want 0 0", valid_out, frame_done);
      end
      bad = 1'b0;
      for (int k = 0; k < 9; k++) if (dout[k] !== 8'sd0) bad = 1'b1;
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL reset_data got data_out0=%0d data_out8=%0d want all 0", dout[0], dout[8]);
      end
      checks++;
      if (pix_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready got %0b want 1", pix_ready);
      end
`ifdef POOL_WIN_CNT_EN
      checks++;
      if (win_count !== 16'd0) begin
         failures++;
         $display("FAIL reset_win_count got %0d want 0", win_count);
      end
`endif
      rst = 1'b0;

      // Two continuous frames back-to-back.
      stream(36, 1'b0, 1'b1);
      stream(36, 1'b0, 1'b1);

      // Partial frame, then reset mid-frame after pixel 20.
      stream(21, 1'b0, 1'b1);
      @(negedge clk);
      pix_valid = 1'b0;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL partial_windows got %0d pending want 0", sb.size());
      end
      rst       = 1'b1;
      win_model = 0;
      last_v    = -1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (valid_out !== 1'b0 || frame_done !== 1'b0 || pix_ready !== 1'b1) begin
         failures++;
         $display("FAIL post_reset got valid_out=%0b frame_done=%0b pix_ready=%0b want 0 0 1",
                  valid_out, frame_done, pix_ready);
      end

      // Full continuous frame, then a frame with random pix_valid gaps.
      stream(36, 1'b0, 1'b1);
      stream(36, 1'b1, 1'b0);
      drain();
      checks++;
      if (win_model != 8) begin
         failures++;
         $display("FAIL windows_two_frames got %0d want 8", win_model);
      end
`ifdef POOL_WIN_CNT_EN
      checks++;
      if (win_count !== 16'd8) begin
         failures++;
         $display("FAIL win_count_two_frames got %0d want 8", win_count);
      end
`endif

      stream(36, 1'b1, 1'b0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got no finish want finish");
      $fatal(1, "timeout");
   end
endmodule
